// File: rtl/reorder_buffer_pkg.sv
// Shared definitions for the reorder buffer slice: widths, empty markers,
// per-entry record and tag/index helpers.
// Optional feature macro: ROB_BYPASS_EN (operand bypass lookup helpers).
package reorder_buffer_pkg;

    localparam int unsigned robSize   = 16;
    localparam int unsigned dataWidth = 32;
    localparam int unsigned regWidth  = 5;
    localparam int unsigned tagWidth  = 5;
    localparam int unsigned ptrWidth  = $clog2(robSize);

    typedef logic [tagWidth-1:0]  tag_t;
    typedef logic [regWidth-1:0]  reg_t;
    typedef logic [dataWidth-1:0] data_t;
    typedef logic [ptrWidth-1:0]  ptr_t;

    localparam tag_t  emptyTag  = '0;
    localparam reg_t  emptyReg  = '0;
    localparam data_t emptyData = '0;

    typedef struct packed {
        logic  busy;
        logic  ready;
        reg_t  rd;
        data_t value;
        logic  mispredict;
        data_t target;
    } rob_entry_t;

    // Tag 0 is emptyTag; tags above robSize name no entry.
    function automatic logic tag_in_range(input tag_t t);
        return (t != emptyTag) && (t <= tag_t'(robSize));
    endfunction

    function automatic ptr_t tag_to_idx(input tag_t t);
        return ptr_t'(t - tag_t'(1));
    endfunction

    function automatic tag_t idx_to_tag(input ptr_t p);
        return tag_t'(p) + tag_t'(1);
    endfunction

`ifdef ROB_BYPASS_EN
    typedef struct packed {
        logic  ready;
        data_t data;
    } bypass_t;

    // Operand lookup: a matching CDB broadcast this cycle wins over stored state.
    function automatic bypass_t bypass_lookup(input tag_t q, input rob_entry_t e,
                                              input logic cv, input tag_t ct,
                                              input data_t cd);
        bypass_t r;
        r.ready = 1'b0;
        r.data  = e.value;
        if (tag_in_range(q) && e.busy) begin
            if (cv && ct == q) begin
                r.ready = 1'b1;
                r.data  = cd;
            end else begin
                r.ready = e.ready;
            end
        end
        return r;
    endfunction
`endif

endpackage

// File: rtl/reorder_buffer_if.sv
// Pipeline-side bundle of the reorder buffer: issue, CDB, commit and clear.
// Optional feature macro: ROB_BYPASS_EN adds the q1/q2 operand lookup signals.
interface reorder_buffer_if;
    import reorder_buffer_pkg::*;

    logic  issue_valid;
    reg_t  issue_rd;
    logic  rob_full;
    tag_t  alloc_tag;
    logic  cdb_valid;
    tag_t  cdb_tag;
    data_t cdb_data;
    logic  cdb_mispredict;
    data_t cdb_target;
    logic  if_commit;
    reg_t  pos_commit;
    data_t data_commit;
    tag_t  tag_commit;
    logic  clear;
    data_t clear_pc;
`ifdef ROB_BYPASS_EN
    tag_t  q1_tag;
    tag_t  q2_tag;
    logic  q1_ready;
    logic  q2_ready;
    data_t q1_data;
    data_t q2_data;

    modport master (
        output issue_valid, issue_rd, cdb_valid, cdb_tag, cdb_data, cdb_mispredict, cdb_target,
               q1_tag, q2_tag,
        input  rob_full, alloc_tag, if_commit, pos_commit, data_commit, tag_commit, clear, clear_pc,
               q1_ready, q2_ready, q1_data, q2_data
    );
    modport slave (
        input  issue_valid, issue_rd, cdb_valid, cdb_tag, cdb_data, cdb_mispredict, cdb_target,
               q1_tag, q2_tag,
        output rob_full, alloc_tag, if_commit, pos_commit, data_commit, tag_commit, clear, clear_pc,
               q1_ready, q2_ready, q1_data, q2_data
    );
`else
    modport master (
        output issue_valid, issue_rd, cdb_valid, cdb_tag, cdb_data, cdb_mispredict, cdb_target,
        input  rob_full, alloc_tag, if_commit, pos_commit, data_commit, tag_commit, clear, clear_pc
    );
    modport slave (
        input  issue_valid, issue_rd, cdb_valid, cdb_tag, cdb_data, cdb_mispredict, cdb_target,
        output rob_full, alloc_tag, if_commit, pos_commit, data_commit, tag_commit, clear, clear_pc
    );
`endif

endinterface

// File: rtl/reorder_buffer_ptr_ctrl.sv
// Head/tail/count bookkeeping for the reorder buffer ring.
// Fire inputs arrive already qualified by rdy; flush empties the ring.
module rob_ptr_ctrl
    import reorder_buffer_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic flush,
    input  logic issue_fire,
    input  logic commit_fire,
    output ptr_t head,
    output ptr_t tail,
    output logic full,
    output logic empty
);

    logic [ptrWidth:0] count;

    // Pointer and occupancy update; power-of-two size makes the wrap implicit.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (issue_fire)  tail <= tail + ptr_t'(1);
            if (commit_fire) head <= head + ptr_t'(1);
            unique case ({issue_fire, commit_fire})
                2'b10:   count <= count + (ptrWidth+1)'(1);
                2'b01:   count <= count - (ptrWidth+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Occupancy flags straight from the registered count.
    always_comb begin
        full  = (count == (ptrWidth+1)'(robSize));
        empty = (count == '0);
    end

endmodule

// File: rtl/reorder_buffer.sv
// In-order retirement queue feeding the register file commit port.
// Optional feature macro: ROB_BYPASS_EN (combinational q1/q2 operand lookup).
module reorder_buffer
    import reorder_buffer_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             rdy,
    reorder_buffer_if.slave  bus
);

    rob_entry_t entries [robSize];
    ptr_t       head;
    ptr_t       tail;
    logic       full;
    logic       empty;

    logic       clear_q;
    logic       if_commit_q;
    reg_t       pos_q;
    data_t      data_q;
    tag_t       tag_q;
    data_t      clear_pc_q;

    logic       active;
    logic       flush;
    logic       issue_fire;
    logic       commit_fire;
    logic       cdb_hit;
    ptr_t       cdb_idx;
    rob_entry_t head_entry;
    rob_entry_t issue_entry;

    // Qualify issue/CDB/commit; everything in the clear cycle is dropped for the flush.
    always_comb begin
        active      = rdy && !clear_q;
        flush       = rdy && clear_q;
        head_entry  = entries[head];
        cdb_idx     = tag_to_idx(bus.cdb_tag);
        issue_fire  = active && bus.issue_valid && !full;
        commit_fire = active && !empty && head_entry.busy && head_entry.ready;
        cdb_hit     = active && bus.cdb_valid && tag_in_range(bus.cdb_tag) && entries[cdb_idx].busy;
        issue_entry      = '0;
        issue_entry.busy = 1'b1;
        issue_entry.rd   = bus.issue_rd;
    end

    rob_ptr_ctrl u_ptr (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .issue_fire  (issue_fire),
        .commit_fire (commit_fire),
        .head        (head),
        .tail        (tail),
        .full        (full),
        .empty       (empty)
    );

    // Entry array: CDB capture, tail allocation, head invalidation on retire.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            for (int unsigned i = 0; i < robSize; i++) entries[i] <= '0;
        end else begin
            if (cdb_hit) begin
                entries[cdb_idx].ready      <= 1'b1;
                entries[cdb_idx].value      <= bus.cdb_data;
                entries[cdb_idx].mispredict <= bus.cdb_mispredict;
                entries[cdb_idx].target     <= bus.cdb_target;
            end
            if (issue_fire)  entries[tail] <= issue_entry;
            if (commit_fire) entries[head] <= '0;
        end
    end

    // Registered commit/clear pulses; held while rdy is low and dropped after a flush.
    always_ff @(posedge clk) begin
        if (rst) begin
            if_commit_q <= 1'b0;
            clear_q     <= 1'b0;
            pos_q       <= emptyReg;
            data_q      <= emptyData;
            tag_q       <= emptyTag;
            clear_pc_q  <= emptyData;
        end else if (rdy) begin
            if (clear_q) begin
                if_commit_q <= 1'b0;
                clear_q     <= 1'b0;
            end else begin
                if_commit_q <= commit_fire && (head_entry.rd != emptyReg);
                clear_q     <= commit_fire && head_entry.mispredict;
                if (commit_fire && head_entry.rd != emptyReg) begin
                    pos_q  <= head_entry.rd;
                    data_q <= head_entry.value;
                    tag_q  <= idx_to_tag(head);
                end
                if (commit_fire && head_entry.mispredict) clear_pc_q <= head_entry.target;
            end
        end
    end

    // Output drive; pulses are masked while the pipeline is stalled.
    always_comb begin
        bus.rob_full    = full;
        bus.alloc_tag   = idx_to_tag(tail);
        bus.if_commit   = if_commit_q && rdy;
        bus.clear       = clear_q && rdy;
        bus.pos_commit  = pos_q;
        bus.data_commit = data_q;
        bus.tag_commit  = tag_q;
        bus.clear_pc    = clear_pc_q;
    end

`ifdef ROB_BYPASS_EN
    bypass_t q1_res;
    bypass_t q2_res;

    // Operand lookup for the decoder, with same-cycle CDB forwarding.
    always_comb begin
        q1_res = bypass_lookup(bus.q1_tag, entries[tag_to_idx(bus.q1_tag)],
                               bus.cdb_valid, bus.cdb_tag, bus.cdb_data);
        q2_res = bypass_lookup(bus.q2_tag, entries[tag_to_idx(bus.q2_tag)],
                               bus.cdb_valid, bus.cdb_tag, bus.cdb_data);
        bus.q1_ready = q1_res.ready;
        bus.q1_data  = q1_res.data;
        bus.q2_ready = q2_res.ready;
        bus.q2_data  = q2_res.data;
    end
`endif

endmodule

// File: tb/tb_reorder_buffer.sv
// Self-checking bench for reorder_buffer: directed scenarios then random
// traffic, compared every cycle against a queue-based program-order model.
// Optional feature macro: ROB_BYPASS_EN (also checks the q1/q2 lookup).
module tb_reorder_buffer;
    import reorder_buffer_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic rdy;
    always #5 clk = ~clk;

    reorder_buffer_if bus();

    reorder_buffer dut (
        .clk (clk),
        .rst (rst),
        .rdy (rdy),
        .bus (bus)
    );

    typedef struct {
        int unsigned tag;
        int unsigned rd;
        bit          ready;
        logic [31:0] value;
        bit          mis;
        logic [31:0] target;
    } m_ent_t;

    m_ent_t      mq[$];
    int unsigned m_next_tag;
    bit          m_if;
    bit          m_clear;
    logic [31:0] m_pos, m_data, m_tag, m_cpc;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    task automatic check_val(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_next_tag = 1;
        m_if = 0; m_clear = 0;
        m_pos = 0; m_data = 0; m_tag = 0; m_cpc = 0;
    endtask

    // Program-order model: one clock edge worth of behaviour from the current inputs.
    task automatic model_step();
        m_ent_t hd;
        bit     full, commit;
        if (rst) begin model_reset(); return; end
        if (!rdy) return;
        if (m_clear) begin
            mq.delete();
            m_next_tag = 1;
            m_clear = 0; m_if = 0;
            return;
        end
        full   = (mq.size() == 16);
        commit = (mq.size() > 0) && mq[0].ready;
        if (commit) hd = mq[0];
        if (bus.cdb_valid)
            foreach (mq[i])
                if (mq[i].tag == int'(bus.cdb_tag)) begin
                    mq[i].ready  = 1;
                    mq[i].value  = bus.cdb_data;
                    mq[i].mis    = bus.cdb_mispredict;
                    mq[i].target = bus.cdb_target;
                end
        if (commit) begin
            void'(mq.pop_front());
            m_if = (hd.rd != 0);
            if (hd.rd != 0) begin m_pos = hd.rd; m_data = hd.value; m_tag = hd.tag; end
            m_clear = hd.mis;
            if (hd.mis) m_cpc = hd.target;
        end else begin
            m_if = 0; m_clear = 0;
        end
        if (bus.issue_valid && !full) begin
            mq.push_back('{tag: m_next_tag, rd: bus.issue_rd, ready: 0, value: 0, mis: 0, target: 0});
            m_next_tag = (m_next_tag == 16) ? 1 : m_next_tag + 1;
        end
    endtask

    task automatic check_outputs();
        bit full;
        full = (mq.size() == 16);
        check_val("rob_full", bus.rob_full, full);
        if (!full) check_val("alloc_tag", bus.alloc_tag, m_next_tag);
        check_val("if_commit", bus.if_commit, m_if && rdy);
        check_val("clear", bus.clear, m_clear && rdy);
        check_val("pos_commit", bus.pos_commit, m_pos);
        check_val("data_commit", bus.data_commit, m_data);
        check_val("tag_commit", bus.tag_commit, m_tag);
        check_val("clear_pc", bus.clear_pc, m_cpc);
    endtask

`ifdef ROB_BYPASS_EN
    task automatic check_bypass(input string name, input int unsigned q, input logic got_r,
                                input logic [31:0] got_d);
        bit          exp_r = 0;
        logic [31:0] exp_d = 0;
        foreach (mq[i])
            if (mq[i].tag == q) begin
                if (bus.cdb_valid && int'(bus.cdb_tag) == q) begin
                    exp_r = 1; exp_d = bus.cdb_data;
                end else begin
                    exp_r = mq[i].ready; exp_d = mq[i].value;
                end
            end
        check_val(name, got_r, exp_r);
        if (exp_r) check_val({name, "_data"}, got_d, exp_d);
    endtask
`endif

    task automatic idle();
        rst = 0; rdy = 1;
        bus.issue_valid = 0; bus.issue_rd = 0;
        bus.cdb_valid = 0; bus.cdb_tag = 0; bus.cdb_data = 0;
        bus.cdb_mispredict = 0; bus.cdb_target = 0;
`ifdef ROB_BYPASS_EN
        bus.q1_tag = 0; bus.q2_tag = 0;
`endif
    endtask

    // One clock: check lookups pre-edge, advance model, sample away from the edge.
    task automatic tick();
`ifdef ROB_BYPASS_EN
        #1;
        check_bypass("q1_ready", bus.q1_tag, bus.q1_ready, bus.q1_data);
        check_bypass("q2_ready", bus.q2_tag, bus.q2_ready, bus.q2_data);
`endif
        model_step();
        @(posedge clk);
        @(negedge clk);
        check_outputs();
        idle();
    endtask

    task automatic do_reset();
        rst = 1;
        tick();
    endtask

    task automatic issue(input int unsigned rd);
        bus.issue_valid = 1; bus.issue_rd = reg_t'(rd);
        tick();
    endtask

    task automatic cdb(input int unsigned tag, input logic [31:0] data, input bit mis,
                       input logic [31:0] tgt);
        bus.cdb_valid = 1; bus.cdb_tag = tag_t'(tag); bus.cdb_data = data;
        bus.cdb_mispredict = mis; bus.cdb_target = tgt;
        tick();
    endtask

    initial begin
        idle();
        model_reset();
        @(negedge clk);
        do_reset();

        // Single instruction: result visible two cycles after broadcast.
        check_val("s1_alloc", bus.alloc_tag, 1);
        issue(3);
        cdb(1, 32'h55, 0, 0);
        check_val("s1_early", bus.if_commit, 0);
        tick();
        check_val("s1_if", bus.if_commit, 1);
        check_val("s1_pos", bus.pos_commit, 3);
        check_val("s1_data", bus.data_commit, 32'h55);
        check_val("s1_tag", bus.tag_commit, 1);
        tick();
        check_val("s1_drop", bus.if_commit, 0);

        // Out-of-order completion retires in order.
        do_reset();
        issue(4); issue(5);
        cdb(2, 32'hA2, 0, 0);
        cdb(1, 32'hA1, 0, 0);
        tick();
        check_val("s2_tag1", bus.tag_commit, 1);
        check_val("s2_data1", bus.data_commit, 32'hA1);
        tick();
        check_val("s2_tag2", bus.tag_commit, 2);
        check_val("s2_if2", bus.if_commit, 1);

        // Fill, refused issue, commit frees a slot, tail wraps to tag 1.
        do_reset();
        for (int unsigned i = 0; i < 16; i++) issue(i % 7 + 1);
        check_val("s3_full", bus.rob_full, 1);
        bus.cdb_valid = 1; bus.cdb_tag = 1; bus.cdb_data = 32'hF1;
        bus.issue_valid = 1; bus.issue_rd = 9;
        tick();
        check_val("s3_still_full", bus.rob_full, 1);
        bus.issue_valid = 1; bus.issue_rd = 9;
        tick();
        check_val("s3_not_full", bus.rob_full, 0);
        check_val("s3_wrap", bus.alloc_tag, 1);
        issue(6);
        check_val("s3_refull", bus.rob_full, 1);

        // Mispredicted branch at head flushes everything.
        do_reset();
        issue(0); issue(2);
        cdb(1, 32'h4, 1, 32'h100);
        tick();
        check_val("s4_clear", bus.clear, 1);
        check_val("s4_pc", bus.clear_pc, 32'h100);
        bus.issue_valid = 1; bus.issue_rd = 7;
        bus.cdb_valid = 1; bus.cdb_tag = 2; bus.cdb_data = 32'h77;
        tick();
        check_val("s4_clear_drop", bus.clear, 0);
        check_val("s4_empty", bus.alloc_tag, 1);

        // rd=0 retires silently; rdy low freezes everything.
        do_reset();
        issue(0);
        bus.cdb_valid = 1; bus.cdb_tag = 1; bus.cdb_data = 32'h9;
        rdy = 0;
        tick();
        for (int unsigned i = 0; i < 3; i++) begin
            rdy = 0; bus.issue_valid = 1; bus.issue_rd = 5;
            tick();
            check_val("s5_hold_tag", bus.alloc_tag, 2);
        end
        cdb(1, 32'h9, 0, 0);
        tick();
        check_val("s5_silent", bus.if_commit, 0);
        check_val("s5_retired", bus.alloc_tag, 2);

        // Random traffic against the model.
        for (int unsigned cyc = 0; cyc < 4000; cyc++) begin
            rst = ($urandom_range(0, 599) == 0);
            rdy = ($urandom_range(0, 9) != 0);
            bus.issue_valid = $urandom_range(0, 1);
            bus.issue_rd = reg_t'($urandom_range(0, 7));
            bus.cdb_valid = ($urandom_range(0, 2) != 0);
            if (mq.size() > 0 && $urandom_range(0, 3) != 0)
                bus.cdb_tag = tag_t'(mq[$urandom_range(0, mq.size() - 1)].tag);
            else
                bus.cdb_tag = tag_t'($urandom_range(0, 16));
            bus.cdb_data = $urandom;
            bus.cdb_mispredict = ($urandom_range(0, 24) == 0);
            bus.cdb_target = $urandom;
`ifdef ROB_BYPASS_EN
            bus.q1_tag = ($urandom_range(0, 1) == 1) ? bus.cdb_tag : tag_t'($urandom_range(0, 16));
            bus.q2_tag = tag_t'($urandom_range(0, 16));
`endif
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
